// File: rtl/microop_sequencer_pkg.sv
// Shared types and encodings for the micro-op sequencer.
// The CHN state exists only when MICROOP_CHAIN_EN is defined.
package microop_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LD1  = 3'd1,
      S_LD2  = 3'd2,
      S_EXEC = 3'd3,
      S_WB   = 3'd4,
`ifdef MICROOP_CHAIN_EN
      S_CHN  = 3'd6,
`endif
      S_OUT  = 3'd5
   } state_t;

   // Bus codes name the source->destination transfer
   localparam logic [3:0] BUS_R3_OUTR = 4'b0000;
   localparam logic [3:0] BUS_R1_DR1  = 4'b0001;
   localparam logic [3:0] BUS_R2_DR2  = 4'b0010;
   localparam logic [3:0] BUS_R3_R1   = 4'b0011;
   localparam logic [3:0] BUS_AC_R3   = 4'b0100;
   localparam logic [3:0] BUS_NONE    = 4'b1111;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/microop_alu_decode.sv
// Combinational map from the latched ALU op to operand-mux select, carry-in
// and constant operand bits.
module microop_alu_decode
   import microop_sequencer_pkg::*;
(
   input  logic [1:0] op,
   output logic [1:0] alu_s,
   output logic       alu_cin,
   output logic       alu_a,
   output logic       alu_b
);

   always_comb begin
      alu_s   = 2'b00;
      alu_cin = 1'b0;
      alu_a   = 1'b0;
      alu_b   = 1'b0;
      case (op)
         OP_ADD:  begin alu_s = 2'b00; alu_cin = 1'b0; end
         OP_SUB:  begin alu_s = 2'b01; alu_cin = 1'b1; end
         OP_INC:  begin alu_s = 2'b10; alu_cin = 1'b1; end
         OP_PASS: begin alu_s = 2'b10; alu_cin = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/microop_sequencer.sv
// Moore FSM sequencing register transfers for one ALU micro-op.
// Define MICROOP_CHAIN_EN to add the CHN state (R3->R1) between WB and OUT.
//
// state | meaning
// IDLE  | no transfer, waiting for start
// LD1   | R1 -> DR1
// LD2   | R2 -> DR2
// EXEC  | ALU result -> AC, controls from latched op
// WB    | AC -> R3
// CHN   | R3 -> R1 (chain build only)
// OUT   | R3 -> OUTR, done pulse, may restart
module microop_sequencer
   import microop_sequencer_pkg::*;
#(
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   output logic [SEL_W-1:0] bus_sel,
   output logic             r1_ld,
   output logic             r3_ld,
   output logic             dr1_ld,
   output logic             dr2_ld,
   output logic             ac_ld,
   output logic             outr_ld,
   output logic [1:0]       alu_s,
   output logic             alu_cin,
   output logic             alu_a,
   output logic             alu_b,
   output logic             busy,
   output logic             done
);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_op;
   logic       w_accept;
   logic [1:0] w_dec_s;
   logic       w_dec_cin;
   logic       w_dec_a;
   logic       w_dec_b;

   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_OUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= OP_ADD;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_op <= op;
      end
   end

   microop_alu_decode u_alu_decode (
      .op      (r_op),
      .alu_s   (w_dec_s),
      .alu_cin (w_dec_cin),
      .alu_a   (w_dec_a),
      .alu_b   (w_dec_b)
   );

   always_comb begin
      w_state_nxt = r_state;
      bus_sel     = SEL_W'(BUS_NONE);
      r1_ld       = 1'b0;
      r3_ld       = 1'b0;
      dr1_ld      = 1'b0;
      dr2_ld      = 1'b0;
      ac_ld       = 1'b0;
      outr_ld     = 1'b0;
      alu_s       = 2'b00;
      alu_cin     = 1'b0;
      alu_a       = 1'b0;
      alu_b       = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_accept) w_state_nxt = S_LD1;
         end
         S_LD1: begin
            bus_sel     = SEL_W'(BUS_R1_DR1);
            dr1_ld      = 1'b1;
            w_state_nxt = S_LD2;
         end
         S_LD2: begin
            bus_sel     = SEL_W'(BUS_R2_DR2);
            dr2_ld      = 1'b1;
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            ac_ld       = 1'b1;
            alu_s       = w_dec_s;
            alu_cin     = w_dec_cin;
            alu_a       = w_dec_a;
            alu_b       = w_dec_b;
            w_state_nxt = S_WB;
         end
         S_WB: begin
            bus_sel = SEL_W'(BUS_AC_R3);
            r3_ld   = 1'b1;
`ifdef MICROOP_CHAIN_EN
            w_state_nxt = S_CHN;
`else
            w_state_nxt = S_OUT;
`endif
         end
`ifdef MICROOP_CHAIN_EN
         S_CHN: begin
            bus_sel     = SEL_W'(BUS_R3_R1);
            r1_ld       = 1'b1;
            w_state_nxt = S_OUT;
         end
`endif
         S_OUT: begin
            bus_sel     = SEL_W'(BUS_R3_OUTR);
            outr_ld     = 1'b1;
            done        = 1'b1;
            w_state_nxt = w_accept ? S_LD1 : S_IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_microop_sequencer.sv
// Directed bench for microop_sequencer; walks the state sequence per op and
// compares every output against hand-derived per-state values.
module tb_microop_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [3:0] bus_sel;
   logic       r1_ld, r3_ld, dr1_ld, dr2_ld, ac_ld, outr_ld;
   logic [1:0] alu_s;
   logic       alu_cin, alu_a, alu_b, busy, done;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   localparam int ST_IDLE = 0, ST_LD1 = 1, ST_LD2 = 2, ST_EXEC = 3,
                  ST_WB = 4, ST_OUT = 5, ST_CHN = 6;
`ifdef MICROOP_CHAIN_EN
   localparam int SEQ_LEN = 6;
   int seq_st[SEQ_LEN] = '{ST_LD1, ST_LD2, ST_EXEC, ST_WB, ST_CHN, ST_OUT};
`else
   localparam int SEQ_LEN = 5;
   int seq_st[SEQ_LEN] = '{ST_LD1, ST_LD2, ST_EXEC, ST_WB, ST_OUT};
`endif

   microop_sequencer #(.SEL_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .bus_sel (bus_sel),
      .r1_ld   (r1_ld),
      .r3_ld   (r3_ld),
      .dr1_ld  (dr1_ld),
      .dr2_ld  (dr2_ld),
      .ac_ld   (ac_ld),
      .outr_ld (outr_ld),
      .alu_s   (alu_s),
      .alu_cin (alu_cin),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // {bus_sel, r1,r3,dr1,dr2,ac,outr, alu_s,cin,a,b, busy, done}
   function automatic logic [16:0] obs();
      return {bus_sel, r1_ld, r3_ld, dr1_ld, dr2_ld, ac_ld, outr_ld,
              alu_s, alu_cin, alu_a, alu_b, busy, done};
   endfunction

   function automatic logic [16:0] expv(int st, logic [1:0] o);
      logic [4:0] alu;
      case (o)
         2'b00:   alu = 5'b00_0_0_0;
         2'b01:   alu = 5'b01_1_0_0;
         2'b10:   alu = 5'b10_1_0_0;
         default: alu = 5'b10_0_0_0;
      endcase
      case (st)
         ST_LD1:  return {4'h1, 6'b001000, 5'b0, 1'b1, 1'b0};
         ST_LD2:  return {4'h2, 6'b000100, 5'b0, 1'b1, 1'b0};
         ST_EXEC: return {4'hF, 6'b000010, alu,  1'b1, 1'b0};
         ST_WB:   return {4'h4, 6'b010000, 5'b0, 1'b1, 1'b0};
         ST_CHN:  return {4'h3, 6'b100000, 5'b0, 1'b1, 1'b0};
         ST_OUT:  return {4'h0, 6'b000001, 5'b0, 1'b1, 1'b1};
         default: return {4'hF, 6'b000000, 5'b0, 1'b0, 1'b0};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((32'(r1_ld) + 32'(r3_ld) + 32'(dr1_ld) + 32'(dr2_ld) + 32'(ac_ld) + 32'(outr_ld)) > 1) begin
            errors++;
            $display("FAIL onehot_ld: loads=%b required at most one high",
                     {r1_ld, r3_ld, dr1_ld, dr2_ld, ac_ld, outr_ld});
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op = 2'b01;
      step(); step();
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL reset_with_start: got %h exp %h", obs(), expv(ST_IDLE, 2'b00));
      end
      rst = 1'b0; start = 1'b0;
      step();
      mon_en = 1'b1;
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL reset_idle: got %h exp %h", obs(), expv(ST_IDLE, 2'b00));
      end
   endtask

   task automatic test_op(input logic [1:0] o);
      start = 1'b1; op = o;
      step();
      start = 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
         checks++;
         if (obs() !== expv(seq_st[k], o)) begin
            errors++;
            $display("FAIL op%0d_state%0d: got %h exp %h", o, seq_st[k], obs(), expv(seq_st[k], o));
         end
         step();
      end
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL op%0d_return_idle: got %h exp %h", o, obs(), expv(ST_IDLE, 2'b00));
      end
   endtask

   task automatic test_latency();
      int cyc = 0;
      bit seen = 1'b0;
      start = 1'b1; op = 2'b00;
      for (int k = 1; k <= 12 && !seen; k++) begin
         step();
         start = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
            cyc = k;
         end
      end
      checks++;
      if (cyc != SEQ_LEN) begin
         errors++;
         $display("FAIL done_latency: got %0d cycles exp %0d", cyc, SEQ_LEN);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL latency_idle_busy: got %b exp 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      start = 1'b1; op = 2'b01;
      step();
      op = 2'b10;
      for (int i = 0; i < 2 * SEQ_LEN; i++) begin
         checks++;
         if (obs() !== expv(seq_st[i % SEQ_LEN], (i < SEQ_LEN) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL b2b_cycle%0d: got %h exp %h", i, obs(),
                     expv(seq_st[i % SEQ_LEN], (i < SEQ_LEN) ? 2'b01 : 2'b10));
         end
         if (i == 2 * SEQ_LEN - 1) start = 1'b0;
         step();
      end
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL b2b_end_idle: got %h exp %h", obs(), expv(ST_IDLE, 2'b00));
      end
   endtask

   task automatic test_mid_reset();
      start = 1'b1; op = 2'b11;
      step();
      start = 1'b0; op = 2'b00;
      step();
      op = 2'b01;
      step();
      checks++;
      if (obs() !== expv(ST_EXEC, 2'b11)) begin
         errors++;
         $display("FAIL op_toggle_exec: got %h exp %h", obs(), expv(ST_EXEC, 2'b11));
      end
      rst = 1'b1; start = 1'b1;
      step();
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL mid_reset_idle: got %h exp %h", obs(), expv(ST_IDLE, 2'b00));
      end
      rst = 1'b0; start = 1'b0;
      step();
      checks++;
      if (obs() !== expv(ST_IDLE, 2'b00)) begin
         errors++;
         $display("FAIL post_reset_hold: got %h exp %h", obs(), expv(ST_IDLE, 2'b00));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00;
      test_reset();
      test_op(2'b00);
      test_op(2'b01);
      test_op(2'b10);
      test_op(2'b11);
      test_latency();
      test_back_to_back();
      test_mid_reset();
      test_op(2'b01);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/microop_sequencer.md
MICROOP_SEQUENCER -- requirements
Module: microop_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter SEL_W, default 4, SHALL set the width of the bus select output.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to run one micro-op sequence; sampled only in IDLE or OUT.
REQ-006 op  input  2  ALU operation: 00 ADD, 01 SUB, 10 INC, 11 PASS; latched when start is accepted.
REQ-007 bus_sel  output  SEL_W  bus source/destination code.
REQ-008 r1_ld, r3_ld, dr1_ld, dr2_ld, ac_ld, outr_ld  output  1 each  register load enables.
REQ-009 alu_s  output  2  ALU operand mux select.
REQ-010 alu_cin, alu_a, alu_b  output  1 each  ALU carry-in and constant operand bits.
REQ-011 busy  output  1  high while any non-IDLE state is active.
REQ-012 done  output  1  one-cycle pulse in the final state of a sequence.

Function
REQ-013 The state machine SHALL have states IDLE, LD1, LD2, EXEC, WB and OUT, plus CHN when the chain feature is compiled in.
REQ-014 Transitions SHALL be: IDLE->LD1 on start; LD1->LD2->EXEC->WB unconditionally; WB->OUT (or WB->CHN->OUT with the chain feature); OUT->LD1 if start is high, else OUT->IDLE.
REQ-015 Outputs SHALL be Moore-decoded from state; every output not listed for a state SHALL be 0.
REQ-016 In IDLE, bus_sel SHALL be 1111 (no transfer).
REQ-017 In LD1, bus_sel SHALL be 0001 (R1->DR1) and dr1_ld SHALL be 1.
REQ-018 In LD2, bus_sel SHALL be 0010 (R2->DR2) and dr2_ld SHALL be 1.
REQ-019 In EXEC, bus_sel SHALL be 1111 and ac_ld SHALL be 1, with ALU controls from the latched op: ADD s=00,cin=0; SUB s=01,cin=1; INC s=10,a=0,cin=1; PASS s=10,a=0,cin=0; alu_b=0 always.
REQ-020 In WB, bus_sel SHALL be 0100 (AC->R3) and r3_ld SHALL be 1.
REQ-021 In OUT, bus_sel SHALL be 0000 (R3->OUTR), and outr_ld and done SHALL be 1.
REQ-022 Latency SHALL be: start sampled high at edge n puts LD1 in cycle n+1 and done in cycle n+5 (n+6 with the chain feature).
REQ-023 start and op SHALL be ignored in LD1, LD2, EXEC, WB and CHN; op changes there SHALL NOT affect the running sequence.
REQ-024 start high in OUT SHALL latch the new op and enter LD1 with no IDLE bubble; busy SHALL stay 1 across the boundary.
REQ-025 At most one register load enable SHALL be high in any cycle, except in LD1 and LD2 where exactly one is high.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE from any state, including mid-sequence.
REQ-027 rst SHALL clear the latched op to 00.
REQ-028 In the cycle after reset, all outputs SHALL be 0 except bus_sel, which SHALL be 1111.
REQ-029 rst SHALL take priority over start at the same edge.

Configuration
REQ-030 Macro MICROOP_CHAIN_EN, when defined, SHALL add state CHN between WB and OUT, driving bus_sel 0011 (R3->R1) with r1_ld=1, so the result feeds the next op.
REQ-031 When MICROOP_CHAIN_EN is undefined, CHN SHALL NOT exist, r1_ld SHALL be tied 0, and WB SHALL go directly to OUT.

Structure
REQ-032 A shared package SHALL hold the state enum, the bus_sel code constants (0000, 0001, 0010, 0011, 0100, 1111), and the op encoding constants.
REQ-033 One sub-module, microop_alu_decode, SHALL map the latched op to alu_s/alu_cin/alu_a/alu_b combinationally.

Verification
REQ-034 Reset then start=1 with op=00 for one cycle -> LD1..OUT sequence; bus_sel 0001,0010,1111,0100,0000; done high exactly 5 cycles after start.
REQ-035 op=01 -> in EXEC, alu_s=01 and alu_cin=1; op=10 -> alu_s=10, alu_a=0, alu_cin=1.
REQ-036 start held high continuously -> back-to-back sequences; LD1 directly follows OUT; busy never drops.
REQ-037 rst asserted during EXEC -> next cycle IDLE, bus_sel=1111, all enables 0, busy=0; an op toggled mid-sequence -> no effect on EXEC controls.
REQ-038 With MICROOP_CHAIN_EN defined -> CHN cycle shows bus_sel=0011 and r1_ld=1; done arrives 6 cycles after start.
REQ-039 Every cycle -> assertion that at most one load enable is high.
